mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester arbiter and access sequencer for one port (A or B) of the banked 1024×16 `doublemem` store. It sits between two clients, such as an instruction fetch and a load/store unit or a test FSM, and the memory port's `data`/`addr`/`we`/`q` pins. It grants one access at a time with round-robin fairness. For reads, it holds the address through the data-return cycle, because the memory's bank-select output mux decodes `addr[9]` combinationally.

## Interface
Parameters:
- `DATA_WIDTH`, 16: data word width.
- `ADDR_WIDTH`, 10: address width; bit `ADDR_WIDTH-1` selects the bank.
- `MAX_LOCK`, 4: maximum consecutive beats under lock (used only with `MEMARB_LOCK_EN`).

Ports (one clock; reset is asynchronous and active-low):
- `Clock` in 1: the single clock; all state changes on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `req` in 2: per-requester access request; bit i belongs to requester i.
- `we` in 2: per-requester write (1) or read (0).
- `addr0`, `addr1` in `ADDR_WIDTH`: per-requester address.
- `wdata0`, `wdata1` in `DATA_WIDTH`: per-requester write data.
- `lock` in 2: per-requester request to keep the grant for following beats (used only with `MEMARB_LOCK_EN`).
- `gnt` out 2: one-hot pulse marking the cycle an access is accepted.
- `rvalid` out 2: one-hot pulse marking the cycle read data is valid.
- `rdata` out `DATA_WIDTH`: read data; valid only while `rvalid` is nonzero.
- `mem_addr` out `ADDR_WIDTH`, `mem_data` out `DATA_WIDTH`, `mem_we` out 1: memory port drive.
- `mem_q` in `DATA_WIDTH`: memory port output.

## Operation
FSM states:
- **IDLE**
  - No `req`: drive `mem_we`=0, `gnt`=0. `mem_addr` holds the last issued address.
  - Any `req` set: pick a winner, drive `gnt`, `mem_addr`, `mem_data` and `mem_we` from the winner in the same cycle.
  - Winner is writing: stay in IDLE. Back-to-back accesses are then allowed, one per cycle.
  - Winner is reading: go to RD_WAIT and latch `owner` and `addr_hold`.
- **RD_WAIT**
  - Drive `mem_addr`=`addr_hold`, `mem_we`=0, `gnt`=0.
  - Drive `rvalid[owner]`=1 and `rdata`=`mem_q`.
  - Next state is always IDLE; new requests wait one cycle.

Winner selection:
- Winner selection is round-robin; the pointer names the requester favoured on a tie.
- The pointer resets to 0.
- After every grant, the pointer moves to the non-winner.
- With only one `req` set, that requester wins regardless of the pointer.

Requester rules:
- A requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`.
- Dropping `req` before grant is legal; that access is simply never issued.
- After a read grant, a requester may re-assert `req` immediately; it is arbitrated on the cycle after its `rvalid`.

Other rules:
- Addresses pass through unmodified; no wrap or width arithmetic is applied.
- Bank selection belongs entirely to the memory.
- Reset values: `gnt`=0, `rvalid`=0, `rdata`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0, state=IDLE, pointer=0.
- Reset asserted in RD_WAIT abandons the read: `rvalid` is never pulsed for it.

## Timing
- Grant is combinational: the access is accepted on the rising edge that ends the `gnt` cycle.
- Write latency: the write commits at the edge ending the `gnt` cycle. A write costs 1 cycle of occupancy.
- Read latency: `rvalid`/`rdata` are valid in the cycle right after `gnt`. A read costs 2 cycles of occupancy.
- Peak throughput: 1 write/cycle, or 1 read per 2 cycles.
- A read and a write to the same address in consecutive grants: the read returns the data as it stood before the write.

## Configuration
`MEMARB_LOCK_EN`:
- **Defined:**
  - If the winner has `lock` set at grant, the pointer does not advance and the other requester is masked.
  - The lock lasts while the winner holds `lock`, or for up to `MAX_LOCK` grants, whichever ends first.
  - Once the limit is reached, the pointer is forced to the other requester for one arbitration.
  - A 3-bit beat counter resets to 0 and clears on lock release.
- **Undefined:** the `lock` port exists but is ignored, and there is no counter logic.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state encoding `S_IDLE`=1'b0 and `S_RD_WAIT`=1'b1;
  - the requester index constants;
  - the `MAX_LOCK` default.
- Natural sub-module: `rr_pick2`, a combinational 2-way round-robin picker (req, pointer, mask → one-hot winner). It is instantiated once.

## Test plan
- After reset: all outputs are 0. `req`=2'b01, `we0`=1, `addr0`=10'd5, `wdata0`=16'h00AA → `gnt`=01 the same cycle; a later read of address 5 returns 16'h00AA.
- Both request reads at once, `addr0`=10'd1, `addr1`=10'd2 → `gnt`=01 then `rvalid`=01; `gnt`=10 then `rvalid`=10 (winner/`rvalid` sequence 0,0,1,1). `rdata` shows the preloaded values.
- Bank-hold check: requester 0 reads 10'd512 while requester 1 is waiting to read 10'd3 → `rdata` during requester 0's `rvalid` is the bank-1 word, not the bank-0 word.
- Both request writes continuously for 6 cycles → `gnt` alternates 01, 10, 01, 10, … with a grant every cycle.
- Reset pulled low in RD_WAIT → `rvalid` stays 0 and `mem_addr`=0. After release, the first grant goes to requester 0.
- With `MEMARB_LOCK_EN` and `MAX_LOCK`=4: requester 0 holds `lock` and `req` while requester 1 also requests → 4 grants to requester 0, then 1 to requester 1. Without the macro, grants alternate.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory port arbiter:
// FSM state encoding, requester indices, lock-length default and a
// small index-to-one-hot helper.
package mem_arb_pkg;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_RD_WAIT = 1'b1
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int MAX_LOCK_DEF = 4;

  // Requester index to one-hot grant/valid vector.
  function automatic logic [1:0] idx_to_oh(input logic idx);
    return (idx == REQ1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker. Masked requesters are ignored;
// a single remaining request wins outright, and on a tie the pointer
// names the winner.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic [1:0] eff_s;

  // Pick a one-hot winner from the unmasked requests.
  always_comb begin
    eff_s = req & ~mask;
    if (eff_s == 2'b11) begin
      gnt = idx_to_oh(ptr);
    end else begin
      gnt = eff_s;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for one port of
// a banked synchronous memory. Writes take one cycle, reads take two: the
// read address is held through the data-return cycle because the memory
// selects the bank combinationally from the address.
// Optional feature macro: MEMARB_LOCK_EN (grant locking for up to
// MAX_LOCK consecutive beats).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_LOCK   = MAX_LOCK_DEF
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [1:0]            lock,
  output logic [1:0]            gnt,
  output logic [1:0]            rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  state_t                  state_q, state_d;
  logic                    ptr_q, ptr_d;
  logic                    owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   addr_hold_q, addr_hold_d;
  logic [ADDR_WIDTH-1:0]   last_addr_q, last_addr_d;
  logic [DATA_WIDTH-1:0]   last_data_q, last_data_d;

  logic [1:0]              mask_s;
  logic [1:0]              pick_s;
  logic                    win_s;
  logic                    granted_s;
  logic                    ptr_next_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [DATA_WIDTH-1:0]   sel_data_s;

  rr_pick2 u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .mask (mask_s),
    .gnt  (pick_s)
  );

  assign win_s      = pick_s[1] ? REQ1 : REQ0;
  assign granted_s  = (state_q == S_IDLE) && (pick_s != 2'b00);
  assign sel_addr_s = (win_s == REQ1) ? addr1 : addr0;
  assign sel_data_s = (win_s == REQ1) ? wdata1 : wdata0;

`ifdef MEMARB_LOCK_EN
  logic [2:0] beat_cnt_q, beat_cnt_d;
  logic       lock_own_q, lock_own_d;
  logic [2:0] beat_nxt_s;

  // While a lock is running and its owner still requests with lock held,
  // hide the other requester from the picker.
  always_comb begin
    if ((beat_cnt_q != 3'd0) && lock[lock_own_q] && req[lock_own_q]) begin
      mask_s = idx_to_oh(~lock_own_q);
    end else begin
      mask_s = 2'b00;
    end
  end

  // Beat counting and pointer update: a locked grant keeps the pointer on
  // the winner until MAX_LOCK beats, then hands priority to the other side.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    lock_own_d = lock_own_q;
    ptr_next_s = ptr_q;
    if ((beat_cnt_q != 3'd0) && (lock_own_q == win_s)) begin
      beat_nxt_s = beat_cnt_q + 3'd1;
    end else begin
      beat_nxt_s = 3'd1;
    end
    if (granted_s) begin
      if (lock[win_s]) begin
        if (int'(beat_nxt_s) >= MAX_LOCK) begin
          beat_cnt_d = 3'd0;
          ptr_next_s = ~win_s;
        end else begin
          beat_cnt_d = beat_nxt_s;
          lock_own_d = win_s;
          ptr_next_s = win_s;
        end
      end else begin
        beat_cnt_d = 3'd0;
        ptr_next_s = ~win_s;
      end
    end else if ((beat_cnt_q != 3'd0) && !lock[lock_own_q]) begin
      beat_cnt_d = 3'd0;
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
  end

  // Lock bookkeeping registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      beat_cnt_q <= 3'd0;
      lock_own_q <= REQ0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      lock_own_q <= lock_own_d;
    end
  end
`else
  logic                unused_lock_s;
  localparam int       unused_max_lock = MAX_LOCK;

  assign unused_lock_s = ^lock;
  assign mask_s        = 2'b00;

  // Plain round-robin: after a grant the non-winner becomes favoured.
  always_comb begin
    if (granted_s) begin
      ptr_next_s = ~win_s;
    end else begin
      ptr_next_s = ptr_q;
    end
  end
`endif

  // Port drive and next-state logic for the IDLE / RD_WAIT sequencer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_next_s;
    owner_d     = owner_q;
    addr_hold_d = addr_hold_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    gnt         = 2'b00;
    rvalid      = 2'b00;
    rdata       = '0;
    mem_addr    = last_addr_q;
    mem_data    = last_data_q;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (granted_s) begin
          gnt         = pick_s;
          mem_addr    = sel_addr_s;
          mem_data    = sel_data_s;
          mem_we      = we[win_s];
          last_addr_d = sel_addr_s;
          last_data_d = sel_data_s;
          if (!we[win_s]) begin
            state_d     = S_RD_WAIT;
            owner_d     = win_s;
            addr_hold_d = sel_addr_s;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        mem_addr = addr_hold_q;
        rvalid   = idx_to_oh(owner_q);
        rdata    = mem_q;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= REQ0;
      owner_q     <= REQ0;
      addr_hold_q <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      addr_hold_q <= addr_hold_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

endmodule
